// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding, field widths
// and a small helper used to size the shared cycle counter.
package pll_seq_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 4;

    typedef enum logic [STATE_W-1:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk_i domain.
module sync_2ff (
    input  logic clk_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: no reset here on purpose; the synchronizer only tracks the input level
    // and flushes itself within two cycles of any reset of the surrounding logic.
    always_ff @(posedge clk_i) begin
        meta_q <= d_i;
        sync_q <= meta_q;
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences a fabric PLL: pulses its reset, waits for and qualifies LOCK, then
// releases the downstream system reset; retries on failure and relocks on loss.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 50,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic               clkin,
    input  logic               reset,
    input  logic               pll_lock_i,
    input  logic               relock_req_i,
    output logic               pll_rst_o,
    output logic               sys_rst_o,
    output logic               ready_o,
    output logic               fail_o,
    output logic [RETRY_W-1:0] retry_cnt_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int CNT_MAX = max3(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    pll_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               lock_s;
    logic               attempt_failed;

    sync_2ff u_lock_sync (
        .clk_i (clkin),
        .d_i   (pll_lock_i),
        .q_o   (lock_s)
    );

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q <= RST_PLL;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    // NOTE: every signal written below gets its default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        retry_d        = retry_q;
        attempt_failed = 1'b0;

        case (state_q)
            RST_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    attempt_failed = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    attempt_failed = 1'b1;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                // Loss of lock after release starts a fresh sequence, not a retry.
                if (!lock_s) begin
                    state_d = RST_PLL;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            FAIL: begin
            end
            default: begin
                state_d = RST_PLL;
                cnt_d   = '0;
                retry_d = '0;
            end
        endcase

        if (attempt_failed) begin
            cnt_d = '0;
            if (retry_q == RETRY_LIMIT) begin
                state_d = FAIL;
            end else begin
                state_d = RST_PLL;
                retry_d = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
            end
        end

        if (relock_req_i) begin
            state_d = RST_PLL;
            cnt_d   = '0;
            retry_d = '0;
        end
    end

    always_comb begin
        pll_rst_o = 1'b0;
        sys_rst_o = 1'b1;
        ready_o   = 1'b0;
        fail_o    = 1'b0;
        case (state_q)
            RST_PLL: pll_rst_o = 1'b1;
            RUN: begin
                sys_rst_o = 1'b0;
                ready_o   = 1'b1;
            end
            FAIL:    fail_o = 1'b1;
            default: begin
            end
        endcase
    end

    assign retry_cnt_o = retry_q;
    assign state_o     = state_q;

endmodule
